dco_lock_ctrl: RTL and testbench

Reference-clocked frequency-lock controller that drives the DCO's `enable` and one-hot `lambda` tap select. It measures the DCO frequency as rising edges of an externally divided DCO clock counted over a fixed window of `clk` cycles. It then steps the tap one stage per decision until the count is within tolerance of a programmed target, and reports lock. It sits directly upstream of the DCO and owns its only control inputs.

---
 rtl/dco_lock_pkg.sv | 24 ++
 rtl/dco_lock_ctrl_if.sv | 40 ++++
 rtl/dco_edge_sync.sv | 38 +++
 rtl/dco_lock_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dco_lock_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dco_lock_pkg.sv
// dco_lock_pkg: shared types and constants for the DCO frequency-lock controller.
package dco_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL
  } state_e;

  localparam int NSTAGE = 8;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] IDX_MIN = 3'd0;
  localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;

  // Tap index to one-hot lambda code; never returns zero.
  function automatic logic [NSTAGE-1:0] tap_onehot(input logic [IDX_W-1:0] idx);
    logic [NSTAGE-1:0] one;
    one = {{(NSTAGE-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/dco_lock_ctrl_if.sv
// dco_lock_ctrl_if: control/status bundle between the host/DCO side and the
// lock controller. meas_cnt exists only when DCO_LOCK_MEAS_OUT_EN is defined.
interface dco_lock_ctrl_if
  import dco_lock_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              enable_req;
  logic              dco_div;
  logic [CNT_W-1:0]  target_cnt;
  logic              enable;
  logic [NSTAGE-1:0] lambda;
  logic              locked;
  logic              sat;
`ifdef DCO_LOCK_MEAS_OUT_EN
  logic [CNT_W-1:0]  meas_cnt;

  modport master (
    output enable_req, dco_div, target_cnt,
    input  enable, lambda, locked, sat, meas_cnt
  );

  modport slave (
    input  enable_req, dco_div, target_cnt,
    output enable, lambda, locked, sat, meas_cnt
  );
`else
  modport master (
    output enable_req, dco_div, target_cnt,
    input  enable, lambda, locked, sat
  );

  modport slave (
    input  enable_req, dco_div, target_cnt,
    output enable, lambda, locked, sat
  );
`endif

endinterface

// File: rtl/dco_edge_sync.sv
// dco_edge_sync: 2-flop synchronizer for the divided DCO clock followed by a
// registered rising-edge detector. One-cycle pulse, 3 clk after the input rise.
module dco_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  // Rising edge on the synchronized level.
  always_comb begin
    pulse_d = s2_q & ~prev_q;
  end

  // Synchronizer, edge-history and pulse flops, all reset low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/dco_lock_ctrl.sv
// dco_lock_ctrl: reference-clocked frequency-lock controller for the DCO.
// Counts divided-DCO edges over a WINDOW-cycle window, steps the one-hot tap
// one stage per evaluation and reports lock after LOCK_N good windows.
// Build option: DCO_LOCK_MEAS_OUT_EN exposes the last window count on meas_cnt.
module dco_lock_ctrl
  import dco_lock_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WINDOW   = 256,
  parameter int SETTLE   = 16,
  parameter int TOL      = 2,
  parameter int LOCK_N   = 4,
  parameter int INIT_IDX = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  dco_lock_ctrl_if.slave  io
);

  localparam int CYC_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int GOOD_W  = $clog2(LOCK_N + 1);

  localparam logic [CYC_W-1:0]      SETTLE_LAST = CYC_W'(SETTLE - 1);
  localparam logic [CYC_W-1:0]      WINDOW_LAST = CYC_W'(WINDOW - 1);
  localparam logic [GOOD_W-1:0]     GOOD_LOCK   = GOOD_W'(LOCK_N);
  localparam logic [CNT_W-1:0]      CNT_MAX     = '1;
  localparam logic signed [CNT_W:0] TOL_S       = (CNT_W + 1)'(TOL);

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic              locked_q, locked_d;
  logic              sat_q, sat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef DCO_LOCK_MEAS_OUT_EN
  logic [CNT_W-1:0]  meas_q, meas_d;
`endif

  logic              edge_pulse;
  logic signed [CNT_W:0] diff;

  dco_edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (io.dco_div),
    .pulse (edge_pulse)
  );

  // Next-state and output computation for the settle/measure/evaluate loop.
  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    locked_d = locked_q;
    sat_d    = sat_q;
    idx_d    = idx_q;
    good_d   = good_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
`ifdef DCO_LOCK_MEAS_OUT_EN
    meas_d   = meas_q;
`endif
    diff = $signed({1'b0, cnt_q}) - $signed({1'b0, io.target_cnt});

    if (!io.enable_req) begin
      // Dropping the request abandons any window; tap and sat are kept.
      state_d  = ST_IDLE;
      enable_d = 1'b0;
      locked_d = 1'b0;
      good_d   = '0;
      cyc_d    = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_SETTLE;
          enable_d = 1'b1;
          cyc_d    = '0;
        end

        ST_SETTLE: begin
          if (cyc_q == SETTLE_LAST) begin
            state_d = ST_MEASURE;
            cyc_d   = '0;
            cnt_d   = '0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end

        ST_MEASURE: begin
          if (edge_pulse && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cyc_q == WINDOW_LAST) begin
            state_d = ST_EVAL;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end

        ST_EVAL: begin
`ifdef DCO_LOCK_MEAS_OUT_EN
          meas_d = cnt_q;
`endif
          cyc_d = '0;
          cnt_d = '0;
          if (diff > TOL_S) begin
            // Too fast: slow down by moving to a longer tap.
            good_d   = '0;
            locked_d = 1'b0;
            if (idx_q != IDX_MAX) begin
              idx_d   = idx_q + 1'b1;
              sat_d   = 1'b0;
              state_d = ST_SETTLE;
            end else begin
              sat_d   = 1'b1;
              state_d = ST_MEASURE;
            end
          end else if (diff < -TOL_S) begin
            // Too slow: speed up by moving to a shorter tap.
            good_d   = '0;
            locked_d = 1'b0;
            if (idx_q != IDX_MIN) begin
              idx_d   = idx_q - 1'b1;
              sat_d   = 1'b0;
              state_d = ST_SETTLE;
            end else begin
              sat_d   = 1'b1;
              state_d = ST_MEASURE;
            end
          end else begin
            sat_d   = 1'b0;
            state_d = ST_MEASURE;
            if (good_q != GOOD_LOCK) begin
              good_d = good_q + 1'b1;
            end
            if (good_d == GOOD_LOCK) begin
              locked_d = 1'b1;
            end
          end
        end

        default: begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
          locked_d = 1'b0;
          good_d   = '0;
          cyc_d    = '0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      locked_q <= 1'b0;
      sat_q    <= 1'b0;
      idx_q    <= IDX_W'(INIT_IDX);
      good_q   <= '0;
      cyc_q    <= '0;
      cnt_q    <= '0;
`ifdef DCO_LOCK_MEAS_OUT_EN
      meas_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      locked_q <= locked_d;
      sat_q    <= sat_d;
      idx_q    <= idx_d;
      good_q   <= good_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
`ifdef DCO_LOCK_MEAS_OUT_EN
      meas_q   <= meas_d;
`endif
    end
  end

  assign io.enable = enable_q;
  assign io.lambda = tap_onehot(idx_q);
  assign io.locked = locked_q;
  assign io.sat    = sat_q;
`ifdef DCO_LOCK_MEAS_OUT_EN
  assign io.meas_cnt = meas_q;
`endif

endmodule

// File: tb/tb_dco_lock_ctrl.sv
// tb_dco_lock_ctrl: directed plus randomized bench for dco_lock_ctrl with a
// behavioural DCO and a decision-level reference model of the lock loop.
module tb_dco_lock_ctrl;

  localparam int CNT_W    = 16;
  localparam int WINDOW   = 256;
  localparam int SETTLE   = 16;
  localparam int TOL      = 2;
  localparam int LOCK_N   = 4;
  localparam int INIT_IDX = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dco_lock_ctrl_if #(.CNT_W(CNT_W)) bus ();

  dco_lock_ctrl #(
    .CNT_W    (CNT_W),
    .WINDOW   (WINDOW),
    .SETTLE   (SETTLE),
    .TOL      (TOL),
    .LOCK_N   (LOCK_N),
    .INIT_IDX (INIT_IDX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (decision level, not cycle level)
  int m_idx;
  int m_good;
  int m_locked;
  int m_sat;
  int m_settle;
  int m_meas;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx    = INIT_IDX;
    m_good   = 0;
    m_locked = 0;
    m_sat    = 0;
    m_settle = 0;
    m_meas   = 0;
  endtask

  // One evaluation of a completed window with cnt edges against tgt.
  task automatic model_eval(input int cnt, input int tgt);
    int d;
    d = cnt - tgt;
    m_meas   = cnt;
    m_settle = 0;
    if (d >= -TOL && d <= TOL) begin
      m_sat = 0;
      if (m_good < LOCK_N) m_good++;
      if (m_good == LOCK_N) m_locked = 1;
    end else begin
      m_good   = 0;
      m_locked = 0;
      if (d < -TOL) begin
        if (m_idx > 0) begin m_idx--; m_sat = 0; m_settle = 1; end
        else m_sat = 1;
      end else begin
        if (m_idx < 7) begin m_idx++; m_sat = 0; m_settle = 1; end
        else m_sat = 1;
      end
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, " lambda"}, 32'(bus.lambda), 32'(1) << m_idx);
    chk({tag, " locked"}, 32'(bus.locked), 32'(m_locked));
    chk({tag, " sat"},    32'(bus.sat),    32'(m_sat));
`ifdef DCO_LOCK_MEAS_OUT_EN
    chk({tag, " meas_cnt"}, 32'(bus.meas_cnt), 32'(m_meas));
`endif
  endtask

  // Raise the request at a negedge; returns at the first MEASURE cycle.
  task automatic start_enable(input string tag);
    chk({tag, " enable before req"}, 32'(bus.enable), 32'd0);
    bus.enable_req = 1'b1;
    @(negedge clk);
    chk({tag, " enable after req"}, 32'(bus.enable), 32'd1);
    repeat (SETTLE) @(negedge clk);
  endtask

  // Called at the first MEASURE cycle: drive n DCO edges inside the window,
  // check the EVAL edge, then skip the settle time if the tap moved.
  task automatic window(input int n, input int tgt, input string tag);
    int start;
    bus.target_cnt = CNT_W'(tgt);
    start = (n > 0) ? int'($urandom_range(2, WINDOW - 4 * n)) : 0;
    for (int c = 0; c < WINDOW; c++) begin
      bus.dco_div = (n > 0) && (c >= start) && (c < start + 4 * n) && (((c - start) % 4) < 2);
      @(negedge clk);
    end
    bus.dco_div = 1'b0;
    chk({tag, " lambda before eval edge"}, 32'(bus.lambda), 32'(1) << m_idx);
    model_eval(n, tgt);
    @(negedge clk);
    chk_outputs({tag, " eval"});
    chk({tag, " enable"}, 32'(bus.enable), 32'd1);
    if (m_settle != 0) repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    int n;

    bus.enable_req = 1'b0;
    bus.dco_div    = 1'b0;
    bus.target_cnt = '0;
    model_reset();

    // Reset state, then held with no request
    repeat (3) @(negedge clk);
    chk_outputs("reset");
    chk("reset enable", 32'(bus.enable), 32'd0);
    chk("reset lambda 0x80", 32'(bus.lambda), 32'h80);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk_outputs("idle hold");
    chk("idle hold enable", 32'(bus.enable), 32'd0);

    // Walk the tap from the slow end to target, then lock
    start_enable("walk");
    for (int i = 0; i < 12 && m_locked == 0; i++)
      window(20 + 4 * (7 - m_idx), 32, "walk");
    chk("walk locked", 32'(bus.locked), 32'd1);
    chk("walk lambda 0x10", 32'(bus.lambda), 32'h10);

    // Too slow at every tap: walk to idx 0, then saturate
    for (int i = 0; i < 10 && m_idx > 0; i++)
      window(10, 50, "sat walk");
    window(10, 50, "sat hit");
    chk("sat asserted", 32'(bus.sat), 32'd1);
    chk("sat lambda 0x01", 32'(bus.lambda), 32'h01);
    window(10, 50, "sat hold");

    // Tolerance boundary: +2 is good, +3 steps the tap and drops lock
    for (int i = 0; i < 8 && m_locked == 0; i++)
      window(42, 40, "tol +2");
    chk("tol +2 locked", 32'(bus.locked), 32'd1);
    chk("tol +2 sat cleared", 32'(bus.sat), 32'd0);
    window(43, 40, "tol +3");
    chk("tol +3 unlocked", 32'(bus.locked), 32'd0);
    chk("tol +3 lambda 0x02", 32'(bus.lambda), 32'h02);

    // Randomized targets and counts
    for (int i = 0; i < 12; i++) begin
      tgt = int'($urandom_range(20, 50));
      n   = tgt + int'($urandom_range(0, 10)) - 5;
      window(n, tgt, "random");
    end

    // Drop the request mid-window after locking
    for (int i = 0; i < 8 && m_locked == 0; i++)
      window(30, 30, "pre-drop");
    chk("pre-drop locked", 32'(bus.locked), 32'd1);
    repeat (WINDOW / 2) @(negedge clk);
    bus.enable_req = 1'b0;
    @(negedge clk);
    m_good   = 0;
    m_locked = 0;
    chk("drop enable", 32'(bus.enable), 32'd0);
    chk_outputs("drop");
    repeat (20) @(negedge clk);
    chk("drop idle enable", 32'(bus.enable), 32'd0);
    start_enable("rearm");
    window(30, 30, "rearm");
    chk("rearm not locked yet", 32'(bus.locked), 32'd0);

    // Asynchronous reset in the middle of a window while locked
    for (int i = 0; i < 8 && m_locked == 0; i++)
      window(30, 30, "pre-reset");
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("async reset");
    chk("async reset enable", 32'(bus.enable), 32'd0);
    bus.enable_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_outputs("post reset hold");
    chk("post reset enable", 32'(bus.enable), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
